// File: rtl/c3po_pkg.sv
// Shared types and default widths for the c3po datapath.
package c3po_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SLICE = 1'b1
  } state_t;

  localparam int C3PO_IN_BYTES  = 160;
  localparam int C3PO_OUT_BYTES = 32;
  localparam int C3PO_DEPTH     = 2;
  localparam int C3PO_ID_W      = 4;

  // Bits needed to hold any count in 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/c3po_beat_fifo.sv
// DEPTH-entry beat buffer; the registered read port doubles as the head-beat holding register.
module c3po_beat_fifo
  import c3po_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         not_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout       <= '0;
    end else begin
      if (push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (pop) begin
        rd_ptr_reg <= bump(rd_ptr_reg);
        dout       <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end

  assign empty    = (count_reg == '0);
  assign not_full = (count_reg < CW'(DEPTH));

endmodule

// File: rtl/c3po_gearbox.sv
// Wide-to-narrow packet gearbox with backpressure and sticky protocol-error flag.
// Define C3PO_GEARBOX_ZERO_PAD_EN to force o_data bytes at index >= o_vbc to zero.
module c3po_gearbox
  import c3po_pkg::*;
#(
  parameter int IN_BYTES  = C3PO_IN_BYTES,
  parameter int OUT_BYTES = C3PO_OUT_BYTES,
  parameter int DEPTH     = C3PO_DEPTH,
  parameter int ID_W      = C3PO_ID_W
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic                           val,
  input  logic                           sop,
  input  logic                           eop,
  input  logic [$clog2(IN_BYTES+1)-1:0]  vbc,
  input  logic [ID_W-1:0]                id,
  input  logic [IN_BYTES*8-1:0]          data,
  output logic                           ready,
  output logic                           o_val,
  output logic                           o_sop,
  output logic                           o_eop,
  output logic [$clog2(OUT_BYTES+1)-1:0] o_vbc,
  output logic [ID_W-1:0]                o_id,
  output logic [OUT_BYTES*8-1:0]         o_data,
  input  logic                           o_ready,
  output logic                           err
);

  localparam int VW = cnt_w(IN_BYTES);
  localparam int OW = cnt_w(OUT_BYTES);
  localparam int DW = IN_BYTES * 8;
  localparam int SW = OUT_BYTES * 8;
  localparam int FW = 2 + VW + ID_W + DW;

  logic            alive_reg;
  logic            in_pkt_reg;
  logic [ID_W-1:0] id_lat_reg;
  logic            err_reg;
  state_t          state_reg;
  logic [VW-1:0]   off_reg;

  logic            accept, push, proto_err;
  logic [VW-1:0]   vbc_clamped;
  logic [ID_W-1:0] beat_id;
  logic            fifo_empty, fifo_not_full, load, handshake, last_slice;
  logic [VW-1:0]   remaining;
  logic [SW-1:0]   slice_raw;

  logic            h_sop, h_eop;
  logic [VW-1:0]   h_vbc;
  logic [ID_W-1:0] h_id;
  logic [DW-1:0]   h_data;
  logic [FW-1:0]   fifo_dout;

  assign accept      = val && ready;
  assign push        = accept && (vbc != '0);
  assign vbc_clamped = (vbc > VW'(IN_BYTES)) ? VW'(IN_BYTES) : vbc;
  assign beat_id     = sop ? id : id_lat_reg;
  // sop==in_pkt covers both "sop inside a packet" and "continuation outside a packet".
  assign proto_err   = (vbc == '0) || (vbc > VW'(IN_BYTES)) || (sop == in_pkt_reg);
  assign ready       = alive_reg && fifo_not_full;
  assign err         = err_reg;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      alive_reg  <= 1'b0;
      in_pkt_reg <= 1'b0;
      id_lat_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      if (accept) begin
        if (sop) id_lat_reg <= id;
        in_pkt_reg <= !eop && (sop || in_pkt_reg);
        if (proto_err) err_reg <= 1'b1;
      end
    end
  end

  c3po_beat_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_L  (reset_L),
    .push     (push),
    .din      ({sop, eop, vbc_clamped, beat_id, data}),
    .pop      (load),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .not_full (fifo_not_full)
  );

  assign {h_sop, h_eop, h_vbc, h_id, h_data} = fifo_dout;

  assign remaining  = h_vbc - off_reg;
  assign last_slice = (remaining <= VW'(OUT_BYTES));
  assign handshake  = o_val && o_ready;
  // Pull the next beat into the holding register on the edge the previous one finishes.
  assign load       = !fifo_empty && ((state_reg == ST_IDLE) || (handshake && last_slice));

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_reg <= ST_IDLE;
      off_reg   <= '0;
    end else if (load) begin
      state_reg <= ST_SLICE;
      off_reg   <= '0;
    end else if (handshake) begin
      if (last_slice) begin
        state_reg <= ST_IDLE;
        off_reg   <= '0;
      end else begin
        off_reg <= off_reg + VW'(OUT_BYTES);
      end
    end
  end

  assign o_val     = (state_reg == ST_SLICE);
  assign o_sop     = o_val && h_sop && (off_reg == '0);
  assign o_eop     = o_val && h_eop && last_slice;
  assign o_vbc     = last_slice ? remaining[OW-1:0] : OW'(OUT_BYTES);
  assign o_id      = h_id;
  assign slice_raw = SW'(h_data >> {off_reg, 3'b000});

`ifdef C3PO_GEARBOX_ZERO_PAD_EN
  genvar gi;
  generate
    for (gi = 0; gi < OUT_BYTES; gi++) begin : g_pad
      assign o_data[8*gi +: 8] = (OW'(gi) < o_vbc) ? slice_raw[8*gi +: 8] : 8'h00;
    end
  endgenerate
`else
  assign o_data = slice_raw;
`endif

endmodule

// File: tb/tb_c3po_gearbox.sv
// Bench for c3po_gearbox: vector table, directed corner sequences and random traffic vs a slice model.
module tb_c3po_gearbox;

  localparam int IN_BYTES  = 160;
  localparam int OUT_BYTES = 32;
  localparam int DEPTH     = 2;
  localparam int ID_W      = 4;
  localparam int VW        = $clog2(IN_BYTES + 1);
  localparam int OW        = $clog2(OUT_BYTES + 1);
  localparam int DW        = IN_BYTES * 8;
  localparam int SW        = OUT_BYTES * 8;

  logic            clk = 1'b0;
  logic            reset_L = 1'b0;
  logic            val = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [VW-1:0]   vbc = '0;
  logic [ID_W-1:0] id = '0;
  logic [DW-1:0]   data = '0;
  logic            ready;
  logic            o_val, o_sop, o_eop;
  logic [OW-1:0]   o_vbc;
  logic [ID_W-1:0] o_id;
  logic [SW-1:0]   o_data;
  logic            o_ready;
  logic            err;

  always #5 clk = ~clk;

  c3po_gearbox #(
    .IN_BYTES (IN_BYTES), .OUT_BYTES (OUT_BYTES), .DEPTH (DEPTH), .ID_W (ID_W)
  ) dut (
    .clk (clk), .reset_L (reset_L), .val (val), .sop (sop), .eop (eop), .vbc (vbc),
    .id (id), .data (data), .ready (ready), .o_val (o_val), .o_sop (o_sop),
    .o_eop (o_eop), .o_vbc (o_vbc), .o_id (o_id), .o_data (o_data),
    .o_ready (o_ready), .err (err)
  );

  typedef struct {
    logic            sop;
    logic            eop;
    logic [OW-1:0]   vbc;
    logic [ID_W-1:0] id;
    logic [SW-1:0]   data;
  } exp_t;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [VW-1:0] vbc;
    int            n_out;
    int            last_vbc;
    logic          err;
  } vec_t;

  exp_t            expq[$];
  int              total = 0;
  int              bad = 0;
  int              obs_count = 0;
  int              last_vbc = 0;
  int              ordy_mode = 0;
  logic            m_in_pkt = 1'b0;
  logic [ID_W-1:0] m_id = '0;
  logic            m_err = 1'b0;
  logic            prev_stall = 1'b0;
  logic [12:0]     prev_ctl = '0;
  logic [SW-1:0]   prev_data = '0;
  logic            sending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  // Reference: a beat of v valid bytes becomes ceil(v/OUT) slices of min(OUT, remaining) bytes.
  task automatic model_beat(input logic s, input logic e, input int v_in,
                            input logic [ID_W-1:0] i, input logic [DW-1:0] d);
    int v;
    int n;
    exp_t x;
    v = (v_in > IN_BYTES) ? IN_BYTES : v_in;
    if (v_in == 0 || v_in > IN_BYTES || (s && m_in_pkt) || (!s && !m_in_pkt)) m_err = 1'b1;
    if (s) m_id = i;
    n = (v + OUT_BYTES - 1) / OUT_BYTES;
    for (int j = 0; j < n; j++) begin
      x.sop  = s && (j == 0);
      x.eop  = e && (j == n - 1);
      x.vbc  = OW'(((v - j * OUT_BYTES) < OUT_BYTES) ? (v - j * OUT_BYTES) : OUT_BYTES);
      x.id   = m_id;
      x.data = d[j*SW +: SW];
      expq.push_back(x);
    end
    if (e) m_in_pkt = 1'b0;
    else if (s) m_in_pkt = 1'b1;
  endtask

  task automatic model_reset();
    expq.delete();
    m_in_pkt  = 1'b0;
    m_id      = '0;
    m_err     = 1'b0;
    obs_count = 0;
  endtask

  initial begin
    o_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ordy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = ($urandom_range(0, 3) != 0);
        default: o_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard check per accepted output beat plus hold check while stalled.
  always @(negedge clk) begin
    #1;
    if (!reset_L) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_ctl", {o_val, o_sop, o_eop, o_vbc, o_id}, prev_ctl);
        chk("stall_hold_data", (o_data === prev_data), 1);
      end
      if (o_val && o_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got sop=%0b eop=%0b vbc=%0d want no beat", o_sop, o_eop, o_vbc);
        end else begin
          exp_t x;
          logic [SW-1:0] mask;
          x = expq.pop_front();
          for (int k = 0; k < OUT_BYTES; k++) mask[8*k +: 8] = (k < int'(x.vbc)) ? 8'hFF : 8'h00;
          chk("beat_sop", o_sop, x.sop);
          chk("beat_eop", o_eop, x.eop);
          chk("beat_vbc", o_vbc, x.vbc);
          chk("beat_id", o_id, x.id);
          total++;
          if ((o_data & mask) !== (x.data & mask)) begin
            bad++;
            $display("FAIL beat_data: got %h want %h", o_data & mask, x.data & mask);
          end
        end
        obs_count++;
        last_vbc = int'(o_vbc);
        $display("out beat %0d: sop=%0b eop=%0b vbc=%0d id=%0d", obs_count, o_sop, o_eop, o_vbc, o_id);
      end
      prev_stall = o_val && !o_ready;
      prev_ctl   = {o_val, o_sop, o_eop, o_vbc, o_id};
      prev_data  = o_data;
    end
  end

  task automatic send(input logic s, input logic e, input logic [VW-1:0] v,
                      input logic [ID_W-1:0] i, input logic [DW-1:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    val = 1'b1; sop = s; eop = e; vbc = v; id = i; data = d;
    while (!ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1 within 500 cycles");
      val = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(s, e, int'(v), i, d);
  endtask

  task automatic idle();
    @(negedge clk);
    val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || o_val) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0 || o_val) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", expq.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    val     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_o_val", o_val, 0);
    chk("rst_o_ctl", {o_sop, o_eop, o_vbc, o_id}, 0);
    chk("rst_o_data_nz", (o_data != '0), 0);
    chk("rst_err", err, 0);
    model_reset();
    reset_L = 1'b1;
    @(negedge clk);
    chk("rel_ready", ready, 1);
  endtask

  initial begin
    vec_t          tbl[8];
    logic [DW-1:0] d;
    int            n;

    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[8];
    logic [DW-1:0] d;
    int            n;

    tbl[0] = '{1'b1, 1'b1, 8'd32,  1, 32, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'd159, 5, 31, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'd160, 5, 32, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'd1,   1, 1,  1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'd33,  2, 1,  1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'd200, 5, 32, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 8'd0,   0, 0,  1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'd64,  2, 32, 1'b1};

    for (int r = 0; r < 8; r++) begin
      do_reset();
      send(tbl[r].sop, tbl[r].eop, tbl[r].vbc, ID_W'(r), rand_data());
      idle();
      drain();
      chk("tbl_nbeats", obs_count, tbl[r].n_out);
      if (tbl[r].n_out > 0) chk("tbl_last_vbc", last_vbc, tbl[r].last_vbc);
      chk("tbl_err", err, tbl[r].err);
    end

    // Five back-to-back 32-byte single-beat packets.
    do_reset();
    for (int k = 0; k < 5; k++) send(1'b1, 1'b1, 8'd32, ID_W'(k + 1), rand_data());
    idle();
    drain();
    chk("b2b_nbeats", obs_count, 5);
    chk("b2b_err", err, 0);

    // Three-beat packet with word-index payload.
    do_reset();
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = w;
    send(1'b1, 1'b0, 8'd160, 4'd9, d);
    send(1'b0, 1'b0, 8'd160, 4'd2, d);
    send(1'b0, 1'b1, 8'd159, 4'd3, d);
    idle();
    drain();
    chk("multi_nbeats", obs_count, 15);
    chk("multi_err", err, 0);

    // Downstream stall for 20 cycles while upstream keeps pushing.
    do_reset();
    ordy_mode = 2;
    sending   = 1'b1;
    fork
      begin
        for (int k = 0; k < 5; k++) send(1'b1, 1'b1, 8'd160, ID_W'(k), rand_data());
        idle();
        sending = 1'b0;
      end
    join_none
    repeat (20) @(negedge clk);
    chk("stall_ready", ready, 0);
    chk("stall_o_val", o_val, 1);
    ordy_mode = 0;
    n = 0;
    while (sending && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("stall_send_done", sending, 0);
    drain();
    chk("stall_nbeats", obs_count, 25);

    // Zero-length beat then a sop with no prior eop.
    do_reset();
    send(1'b1, 1'b0, 8'd0, 4'd3, rand_data());
    send(1'b1, 1'b1, 8'd64, 4'd5, rand_data());
    idle();
    drain();
    chk("zero_nbeats", obs_count, 2);
    chk("zero_err", err, 1);
    repeat (10) @(negedge clk);
    chk("zero_err_sticky", err, 1);

    // Reset while slice 2 of a full beat is on the output.
    do_reset();
    send(1'b1, 1'b1, 8'd160, 4'd7, rand_data());
    idle();
    n = 0;
    while (obs_count < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("midrst_presenting", o_val, 1);
    reset_L = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_o_val", o_val, 0);
    chk("midrst_ready", ready, 0);
    reset_L = 1'b1;
    @(negedge clk);
    send(1'b1, 1'b1, 8'd32, 4'd6, rand_data());
    idle();
    drain();
    chk("midrst_nbeats", obs_count, 1);
    chk("midrst_err", err, 0);

    // Random packets with random downstream backpressure and occasional protocol faults.
    do_reset();
    ordy_mode = 1;
    for (int p = 0; p < 25; p++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        logic          s;
        logic [VW-1:0] v;
        s = (b == 0);
        if ($urandom_range(0, 11) == 0) s = !s;
        v = VW'($urandom_range(1, IN_BYTES));
        if ($urandom_range(0, 11) == 0)
          v = ($urandom_range(0, 1) == 0) ? '0 : VW'($urandom_range(IN_BYTES + 1, 255));
        send(s, (b == nb - 1), v, ID_W'($urandom_range(0, 15)), rand_data());
      end
    end
    idle();
    drain();
    ordy_mode = 0;
    chk("rand_err", err, m_err);
    chk("rand_pending", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c3po_gearbox.md
# c3po_gearbox

Parametrised packet width down-converter for the c3po datapath. Accepts wide packet beats (`sop`/`eop`/`val`/`vbc`/`id`/`data`) and emits narrow output beats with valid-byte counts. Supports backpressure on both sides through a DEPTH-entry input beat buffer. It succeeds the fixed 160-byte c3po input stage by adding:

- configurable input and output widths;
- output-side `o_ready`;
- `o_id` passthrough;
- sticky protocol-error reporting.

## Interface
Parameters:
- `IN_BYTES`, 160, input beat width in bytes
- `OUT_BYTES`, 32, output beat width in bytes; must be ≤ `IN_BYTES`
- `DEPTH`, 2, input beat buffer entries; must be ≥ 1
- `ID_W`, 4, packet id width

Ports. One clock; reset is synchronous and active-low.
- `clk`  in  1  clock, all logic on rising edge
- `reset_L`  in  1  synchronous active-low reset
- `val`  in  1  input beat valid
- `sop`  in  1  first beat of packet
- `eop`  in  1  last beat of packet
- `vbc`  in  $clog2(IN_BYTES+1)  valid bytes in beat, from byte 0
- `id`  in  ID_W  packet id, sampled on sop beat
- `data`  in  IN_BYTES*8  byte k at `data[8k+:8]`
- `ready`  out  1  beat buffer can accept
- `o_val`  out  1  output beat valid
- `o_sop`  out  1  first output beat of packet
- `o_eop`  out  1  last output beat of packet
- `o_vbc`  out  $clog2(OUT_BYTES+1)  valid bytes in output beat
- `o_id`  out  ID_W  id of packet in flight
- `o_data`  out  OUT_BYTES*8  output bytes
- `o_ready`  in  1  downstream accepts output beat
- `err`  out  1  sticky protocol error

## Operation
- Input handshake: a beat is accepted when `val && ready`. Beats with `val` low are ignored.
- `ready` = (count < DEPTH). It is computed from the registered count only and has no combinational path from `o_ready`.
- Each buffered beat stores sop, eop, clamped vbc, id and data.
- Slicing: the head beat yields ceil(vbc/OUT_BYTES) output beats.
- Slice j carries bytes `[j*OUT_BYTES, …)`.
- `o_vbc` = min(OUT_BYTES, vbc − j*OUT_BYTES).
- `o_sop` is set only on slice 0 of a sop beat.
- `o_eop` is set only on the final slice of an eop beat.
- `o_id` is set from the id latched on the sop beat and is held for all beats of the packet.
- States:
  - IDLE: buffer empty, `o_val`=0.
  - SLICE: presenting slice j of the head beat.
- Transitions:
  - IDLE→SLICE when the buffer becomes non-empty.
  - In SLICE, on `o_val && o_ready`: if more slices remain, j increments. Otherwise the head pops and the state goes to SLICE (buffer non-empty) or IDLE (buffer empty).
- Offset arithmetic uses a byte-offset counter of width $clog2(IN_BYTES+1). The counter resets to 0 on each pop.
- Error conditions set `err`, which stays 1 until reset:
  - vbc=0: beat accepted and discarded, no output.
  - vbc>IN_BYTES: clamped to IN_BYTES.
  - sop while already inside a packet: beat accepted and treated as a new packet.
  - non-sop beat outside a packet: beat forwarded with `o_sop`=0.
- Push and pop in the same cycle are allowed; count is unchanged.

## Timing
- Reset values: `ready`=0 during reset and 1 on the first cycle after reset release. `o_val`=`o_sop`=`o_eop`=0, `o_vbc`=0, `o_id`=0, `o_data`=0, `err`=0. Buffer empty, state IDLE.
- Latency: a beat accepted at edge N into an empty buffer has slice 0 valid after edge N+1.
- Throughput: one output beat per cycle while `o_ready`=1.
- Stall: while `o_val && !o_ready`, all `o_*` outputs are held stable.
- Full buffer: `ready`=0. An upstream beat held with `val`=1 is accepted on the first edge after `ready` returns to 1.
- Reset asserted mid-packet: all state is cleared on that edge and partial packets are discarded. No `o_eop` is emitted for them.

## Configuration
- `C3PO_GEARBOX_ZERO_PAD_EN` defined: `o_data` bytes at index ≥ `o_vbc` are forced to 0.
- Not defined: those bytes are don't-care (raw slice contents). Benches must mask them.

## Structure
- Package `c3po_pkg` holds:
  - the state enum;
  - a byte-count width function;
  - default width constants shared with c3po.
- Sub-module `c3po_beat_fifo`: DEPTH-entry synchronous FIFO with count, storing {sop, eop, vbc, id, data}. The slicing FSM and error logic live in the top level.

## Test plan
All scenarios use defaults (IN_BYTES=160, OUT_BYTES=32) unless stated.
- 5 back-to-back single-beat packets, vbc=32, sop=eop=1 → 5 output beats, each with `o_sop`=`o_eop`=1 and `o_vbc`=32; data matches; `err`=0.
- Single beat, vbc=159 → 5 beats with `o_vbc` 32,32,32,32,31; `o_sop` on beat 1 only, `o_eop` on beat 5 only.
- 3-beat packet, vbc 160/160/159, `data[32i+:32]`=i → 15 output beats, `o_sop` only on the first, `o_eop` only on the last; words appear in order 0..39 per input beat; `o_id` constant.
- `o_ready`=0 for 20 cycles while streaming → `ready` falls after 2 accepted beats plus the one in slicing; `o_*` are stable while stalled; no loss or duplication after release.
- Beat with vbc=0, then a sop beat with no prior eop → no output for the first beat; `err`=1 and stays 1; the second packet is forwarded normally.
- `reset_L`=0 during slice 2 of a 160B beat → next cycle `o_val`=0, `ready`=0. After release, a new 32B packet emits cleanly.
